lstm_axi_sequencer: RTL and testbench
=====================================

# lstm_axi_sequencer

Drives the LSTM AXI4-Lite register block as an AXI4-Lite master on behalf of a streaming datapath: accepts one 16-bit x sample per valid/ready handshake, writes it to the X_IN register, waits for the LSTM stage's `lstm_valid` pulse, reads back y_out and C_out, and presents both on an output stream. Sits directly upstream of the LSTM register block. Weight, bias, C_in and h_in loading is done beforehand by the host, not by this block.

## Interface
- `X_ADDR`, 288: byte address of X_IN register (index 72, step 4, LAYERS=4).
- `Y_ADDR`, 292: byte address of y_out readback register.
- `C_ADDR`, 296: byte address of C_out readback register.
- `TIMEOUT_CYCLES`, 1024: max cycles in WAIT before abort; must be >= 2.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `s_x_data` in 16: input sample (signed fixed point, passed through unmodified).
- `s_x_valid` in 1 / `s_x_ready` out 1: input handshake.
- `m_y_data` out 16, `m_c_data` out 16: result pair.
- `m_valid` out 1 / `m_ready` in 1: output handshake.
- `awaddr` out 32, `awprot` out 3, `awvalid` out 1, `awready` in 1.
- `wdata` out 32, `wstrb` out 4, `wvalid` out 1, `wready` in 1.
- `bresp` in 2, `bvalid` in 1, `bready` out 1.
- `araddr` out 32, `arprot` out 3, `arvalid` out 1, `arready` in 1.
- `rdata` in 32, `rresp` in 2, `rvalid` in 1, `rready` out 1.
- `lstm_ready` in 1, `lstm_valid` in 1: status from LSTM stage.
- `busy` out 1: high in any state except IDLE.
- `resp_err` out 1: sticky; set on any non-zero bresp/rresp.
- `timeout_err` out 1: sticky; set on WAIT timeout.

## Operation
- States: IDLE, WR, WRESP, WAIT, SETTLE, RD_Y, RDATA_Y, RD_C, RDATA_C, OUT.
- IDLE: `s_x_ready = lstm_ready`. On handshake, register x, clear `seen` flag, go to WR.
- WR: `awvalid`, `wvalid` both asserted; `awaddr = X_ADDR`, `wdata = {16'h0, x}`, `wstrb = 4'hF`, prot = 0. Each valid drops independently the cycle after its own ready handshake; leave WR once both accepted (same or different cycles).
- WRESP: `bready = 1`; on `bvalid` go to WAIT; `bresp != 0` sets `resp_err`.
- `seen` flag: set by `lstm_valid` in any of WR/WRESP/WAIT (result can precede B response).
- WAIT: counter from 0; on `seen` or `lstm_valid` go to SETTLE; counter reaching TIMEOUT_CYCLES-1 without it -> set `timeout_err`, go to IDLE, no output.
- SETTLE: 2 cycles, so the slave's y_out (pulse cycle) and delayed C_out (pulse+1) updates have landed.
- RD_Y: `arvalid = 1`, `araddr = Y_ADDR`; on `arready` -> RDATA_Y. RDATA_Y: `rready = 1`; on `rvalid` capture `rdata[15:0]` into `m_y_data` -> RD_C. RD_C/RDATA_C identical with `C_ADDR`, capturing `m_c_data`. `rresp != 0` sets `resp_err`; data still captured.
- OUT: `m_valid = 1`, data stable; on `m_ready` -> IDLE.
- Only one outstanding AXI transaction at a time; no pipelining of samples.

## Timing
- Reset values: all valid/ready outputs 0, `awaddr`/`araddr`/`wdata` 0, `wstrb` 0, prots 0, `m_y_data`/`m_c_data` 0, `busy`/`resp_err`/`timeout_err` 0, state IDLE, counter 0.
- All outputs registered except `s_x_ready`, which is combinational from state and `lstm_ready`.
- Input handshake at cycle T -> `awvalid`/`wvalid` high at T+1.
- Zero-wait slave (ready same cycle, response next): WR 1, WRESP 1, SETTLE 2, each RD+RDATA 2 cycles; `m_valid` rises 2 cycles after SETTLE+reads complete plus WAIT time.
- `lstm_valid` in the same cycle as the timeout limit: treated as seen, no timeout.
- `m_ready` held low: stay in OUT indefinitely; `s_x_ready` stays 0.
- `rst` mid-transaction: immediate return to reset values; in-flight AXI transaction abandoned (slave is reset with the same `rst`).
- Sticky errors cleared only by `rst`.

## Test plan
- Single sample, zero-wait slave model, x=16'h0123, lstm_valid 10 cycles after B: one AW/W at 288 with wdata 32'h0000_0123, reads at 292 then 296, m_y/m_c equal model values (e.g. 16'h00A5/16'h1F00), one m_valid beat.
- awready 3 cycles before wready, random rvalid delays 0-5: exactly one handshake per channel, addresses/data unchanged while valid high.
- lstm_valid asserted during WRESP (before bvalid): no hang, reads proceed after SETTLE.
- No lstm_valid, TIMEOUT_CYCLES=16: timeout_err=1 after 16 WAIT cycles, no AR issued, no m_valid, next sample accepted.
- bresp=2'b10: resp_err=1, flow completes with output; m_ready low 20 cycles: m_valid held, s_x_ready=0, data stable.
- lstm_ready=0 with s_x_valid=1: no acceptance; rst asserted during RDATA_Y: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/lstm_axi_sequencer.sv
// lstm_axi_sequencer
//
// AXI4-Lite master that drives the LSTM register block for a streaming
// datapath. One x sample is accepted per handshake and written to X_IN. The
// block then waits for the LSTM stage's lstm_valid pulse, reads back y_out
// and C_out, and presents the pair on the output stream. Only one AXI
// transaction is outstanding at a time, and samples are not pipelined.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   s_x_data/s_x_valid/s_x_ready  input sample stream (ready is combinational)
//   m_y_data/m_c_data/m_valid/m_ready  result stream
//   aw*/w*/b*/ar*/r*              AXI4-Lite master channels
//   lstm_ready, lstm_valid        status from the LSTM stage
//   busy                          high whenever the FSM is not idle
//   resp_err, timeout_err         sticky error flags, cleared only by rst
module lstm_axi_sequencer #(
    parameter logic [31:0] X_ADDR         = 32'd288,
    parameter logic [31:0] Y_ADDR         = 32'd292,
    parameter logic [31:0] C_ADDR         = 32'd296,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] s_x_data,
    input  logic        s_x_valid,
    output logic        s_x_ready,
    output logic [15:0] m_y_data,
    output logic [15:0] m_c_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] awaddr,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    input  logic        lstm_ready,
    input  logic        lstm_valid,
    output logic        busy,
    output logic        resp_err,
    output logic        timeout_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(1);

    typedef enum logic [3:0] {
        StIdle, StWr, StWresp, StWait, StSettle,
        StRdY, StRdataY, StRdC, StRdataC, StOut
    } state_t;

    state_t          r_state;
    logic [CntW-1:0] r_cnt;
    logic            r_seen;

    logic w_aw_done;
    logic w_w_done;
    logic w_unused_rdata_hi;

    // A channel counts as done if it was already accepted or is accepted now.
    assign w_aw_done = !awvalid || awready;
    assign w_w_done  = !wvalid || wready;

    assign s_x_ready = (r_state == StIdle) && lstm_ready;
    assign awprot    = 3'b000;
    assign arprot    = 3'b000;

    assign w_unused_rdata_hi = ^rdata[31:16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_seen      <= 1'b0;
            awaddr      <= '0;
            awvalid     <= 1'b0;
            wdata       <= '0;
            wstrb       <= '0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            araddr      <= '0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            m_y_data    <= '0;
            m_c_data    <= '0;
            m_valid     <= 1'b0;
            busy        <= 1'b0;
            resp_err    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // The result pulse can arrive before the B response, so remember it.
            if (lstm_valid && (r_state == StWr || r_state == StWresp || r_state == StWait)) begin
                r_seen <= 1'b1;
            end

            case (r_state)
                StIdle: begin
                    if (s_x_valid && lstm_ready) begin
                        r_seen  <= 1'b0;
                        awaddr  <= X_ADDR;
                        awvalid <= 1'b1;
                        wdata   <= {16'h0000, s_x_data};
                        wstrb   <= 4'hF;
                        wvalid  <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= StWr;
                    end
                end
                StWr: begin
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        bready  <= 1'b1;
                        r_state <= StWresp;
                    end
                end
                StWresp: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        if (bresp != 2'b00) resp_err <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    // A pulse coinciding with the last count still wins.
                    if (r_seen || lstm_valid) begin
                        r_cnt   <= '0;
                        r_state <= StSettle;
                    end else if (r_cnt == CntLast) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StSettle: begin
                    // Two cycles: y_out lands on the pulse, C_out one cycle later.
                    if (r_cnt == SettleLast) begin
                        r_cnt   <= '0;
                        araddr  <= Y_ADDR;
                        arvalid <= 1'b1;
                        r_state <= StRdY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StRdY: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= StRdataY;
                    end
                end
                StRdataY: begin
                    if (rvalid) begin
                        rready   <= 1'b0;
                        m_y_data <= rdata[15:0];
                        if (rresp != 2'b00) resp_err <= 1'b1;
                        araddr   <= C_ADDR;
                        arvalid  <= 1'b1;
                        r_state  <= StRdC;
                    end
                end
                StRdC: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= StRdataC;
                    end
                end
                StRdataC: begin
                    if (rvalid) begin
                        rready   <= 1'b0;
                        m_c_data <= rdata[15:0];
                        if (rresp != 2'b00) resp_err <= 1'b1;
                        m_valid  <= 1'b1;
                        r_state  <= StOut;
                    end
                end
                StOut: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_axi_sequencer.sv
// Testbench for lstm_axi_sequencer: directed scenarios against a small
// AXI4-Lite slave model with configurable ready/response delays.
module tb_lstm_axi_sequencer;

    localparam logic [31:0] XA = 32'd288;
    localparam logic [31:0] YA = 32'd292;
    localparam logic [31:0] CA = 32'd296;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] s_x_data = '0;
    logic        s_x_valid = 1'b0;
    logic        s_x_ready;
    logic [15:0] m_y_data, m_c_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        lstm_ready = 1'b1;
    logic        lstm_valid = 1'b0;
    logic        busy, resp_err, timeout_err;

    int n_checks = 0;
    int n_fail = 0;

    // Slave configuration
    int          aw_delay = 0, w_delay = 0, b_delay = 0, r_delay = 0;
    bit          r_rand = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [15:0] y_val = '0, c_val = '0;
    logic [31:0] exp_wdata = '0;

    // Monitor counters
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, mv_beats = 0, prot_err = 0;
    logic [31:0] ar_hist [8];

    always #5 clk = ~clk;

    lstm_axi_sequencer #(
        .X_ADDR(XA), .Y_ADDR(YA), .C_ADDR(CA), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .s_x_data(s_x_data), .s_x_valid(s_x_valid), .s_x_ready(s_x_ready),
        .m_y_data(m_y_data), .m_c_data(m_c_data), .m_valid(m_valid), .m_ready(m_ready),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .lstm_ready(lstm_ready), .lstm_valid(lstm_valid),
        .busy(busy), .resp_err(resp_err), .timeout_err(timeout_err)
    );

    wire [146:0] w_outs = {awvalid, wvalid, bready, arvalid, rready, m_valid, busy, resp_err,
                           timeout_err, awaddr, araddr, wdata, wstrb, awprot, arprot,
                           m_y_data, m_c_data};

    // ---------------- slave model ----------------
    int   aw_cnt, w_cnt, b_wait, r_wait, r_rnd;
    logic aw_got, w_got, b_pend, r_pend;
    logic [31:0] r_addr;
    wire  aw_n = aw_got || (awvalid && awready);
    wire  w_n  = w_got || (wvalid && wready);

    assign awready = awvalid && (aw_cnt >= aw_delay);
    assign wready  = wvalid && (w_cnt >= w_delay);
    assign arready = arvalid;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a == YA) return {16'hDEAD, y_val};
        if (a == CA) return {16'hBEEF, c_val};
        return 32'hFFFF_FFFF;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00; b_pend <= 1'b0; b_wait <= 0;
            rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00; r_pend <= 1'b0; r_wait <= 0;
            r_addr <= '0; r_rnd <= 0;
        end else begin
            r_rnd  <= int'($urandom_range(5, 0));
            aw_cnt <= (!awvalid || awready) ? 0 : aw_cnt + 1;
            w_cnt  <= (!wvalid || wready) ? 0 : w_cnt + 1;
            if (bvalid && bready) bvalid <= 1'b0;
            if (aw_n && w_n) begin
                aw_got <= 1'b0; w_got <= 1'b0;
                if (b_delay == 0) begin
                    bvalid <= 1'b1; bresp <= cfg_bresp;
                end else begin
                    b_pend <= 1'b1; b_wait <= b_delay - 1;
                end
            end else begin
                aw_got <= aw_n; w_got <= w_n;
            end
            if (b_pend) begin
                if (b_wait == 0) begin
                    bvalid <= 1'b1; bresp <= cfg_bresp; b_pend <= 1'b0;
                end else begin
                    b_wait <= b_wait - 1;
                end
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                r_addr <= araddr;
                if ((r_rand ? r_rnd : r_delay) == 0) begin
                    rvalid <= 1'b1; rdata <= rd_word(araddr); rresp <= cfg_rresp;
                end else begin
                    r_pend <= 1'b1; r_wait <= (r_rand ? r_rnd : r_delay) - 1;
                end
            end else if (r_pend) begin
                if (r_wait == 0) begin
                    rvalid <= 1'b1; rdata <= rd_word(r_addr); rresp <= cfg_rresp;
                    r_pend <= 1'b0;
                end else begin
                    r_wait <= r_wait - 1;
                end
            end
        end
    end

    // ---------------- bus monitor ----------------
    logic        mv_hold_q = 1'b0;
    logic [15:0] my_q = '0, mc_q = '0;

    always @(posedge clk) begin
        if (!rst) begin
            if (awvalid && awready) aw_hs <= aw_hs + 1;
            if (wvalid && wready)   w_hs <= w_hs + 1;
            if (bvalid && bready)   b_hs <= b_hs + 1;
            if (arvalid && arready) begin
                ar_hist[ar_hs % 8] <= araddr;
                ar_hs <= ar_hs + 1;
            end
            if (rvalid && rready)   r_hs <= r_hs + 1;
            if (m_valid && m_ready) mv_beats <= mv_beats + 1;
            if ((awvalid && (awaddr !== XA || awprot !== 3'd0)) ||
                (wvalid && (wdata !== exp_wdata || wstrb !== 4'hF)) ||
                (arvalid && arprot !== 3'd0) ||
                (mv_hold_q && (m_valid !== 1'b1 || m_y_data !== my_q || m_c_data !== mc_q)))
                prot_err <= prot_err + 1;
            mv_hold_q <= m_valid && !m_ready;
            my_q      <= m_y_data;
            mc_q      <= m_c_data;
        end else begin
            mv_hold_q <= 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_x(input logic [15:0] x, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        exp_wdata = {16'h0000, x};
        s_x_data  = x;
        s_x_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (s_x_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_x_valid = 1'b0;
    endtask

    task automatic pulse_lstm_after_b(input int dly, input int b0);
        for (int i = 0; i < 100 && b_hs == b0; i++) @(negedge clk);
        n_checks++;
        if (b_hs == b0) begin
            n_fail++;
            $display("FAIL b_response_seen: got none, required one within 100 cycles");
        end
        repeat (dly) @(negedge clk);
        lstm_valid = 1'b1;
        @(negedge clk);
        lstm_valid = 1'b0;
    endtask

    task automatic wait_mvalid(input int bound, output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < bound; i++) begin
            if (m_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic take_output();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_checks++;
        if (w_outs !== '0 || s_x_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: outs=%h s_x_ready=%b, required all zero and ready=1",
                     w_outs, s_x_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int b0, ar0, mv0, cyc;
        bit ok;
        y_val = 16'h00A5; c_val = 16'h1F00;
        b0 = b_hs; ar0 = ar_hs; mv0 = mv_beats;
        send_x(16'h0123, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_accept: got no handshake, required one"); end
        n_checks++;
        if ({awvalid, wvalid, busy} !== 3'b111) begin
            n_fail++;
            $display("FAIL single_wr_latency: aw/w/busy=%b, required 111", {awvalid, wvalid, busy});
        end
        n_checks++;
        if (awaddr !== 32'd288 || wdata !== 32'h0000_0123) begin
            n_fail++;
            $display("FAIL single_wr_fields: awaddr=%0d wdata=%h, required 288 00000123",
                     awaddr, wdata);
        end
        pulse_lstm_after_b(10, b0);
        wait_mvalid(100, ok, cyc);
        n_checks++;
        if (!ok || cyc != 6) begin
            n_fail++;
            $display("FAIL single_out_latency: ok=%b cycles=%0d, required 1 and 6", ok, cyc);
        end
        n_checks++;
        if (m_y_data !== 16'h00A5 || m_c_data !== 16'h1F00) begin
            n_fail++;
            $display("FAIL single_data: y=%h c=%h, required 00a5 1f00", m_y_data, m_c_data);
        end
        n_checks++;
        if (ar_hs - ar0 != 2 || ar_hist[ar0 % 8] !== YA || ar_hist[(ar0 + 1) % 8] !== CA) begin
            n_fail++;
            $display("FAIL single_read_order: n=%0d first=%0d second=%0d, required 2 292 296",
                     ar_hs - ar0, ar_hist[ar0 % 8], ar_hist[(ar0 + 1) % 8]);
        end
        take_output();
        n_checks++;
        if (mv_beats - mv0 != 1 || busy !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_beat: beats=%0d busy=%b m_valid=%b, required 1 0 0",
                     mv_beats - mv0, busy, m_valid);
        end
    endtask

    task automatic test_skewed_ready();
        int aw0, w0, b0, ar0, r0, cyc;
        bit ok;
        aw_delay = 0; w_delay = 3; r_rand = 1'b1;
        y_val = 16'h8001; c_val = 16'h0042;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
        send_x(16'h7FFF, ok);
        pulse_lstm_after_b(2, b0);
        wait_mvalid(100, ok, cyc);
        n_checks++;
        if (!ok || m_y_data !== 16'h8001 || m_c_data !== 16'h0042) begin
            n_fail++;
            $display("FAIL skew_data: ok=%b y=%h c=%h, required 1 8001 0042", ok, m_y_data,
                     m_c_data);
        end
        take_output();
        n_checks++;
        if (aw_hs - aw0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1 || ar_hs - ar0 != 2 ||
            r_hs - r0 != 2) begin
            n_fail++;
            $display("FAIL skew_handshakes: aw=%0d w=%0d b=%0d ar=%0d r=%0d, required 1 1 1 2 2",
                     aw_hs - aw0, w_hs - w0, b_hs - b0, ar_hs - ar0, r_hs - r0);
        end
        n_checks++;
        if (prot_err != 0) begin
            n_fail++;
            $display("FAIL skew_stability: violations=%0d, required 0", prot_err);
        end
        w_delay = 0; r_rand = 1'b0;
    endtask

    task automatic test_lstm_in_wresp();
        int cyc;
        bit ok;
        b_delay = 4;
        y_val = 16'h1234; c_val = 16'hFEDC;
        send_x(16'h0BAD, ok);
        @(negedge clk);
        n_checks++;
        if (bready !== 1'b1 || bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL early_in_wresp: bready=%b bvalid=%b, required 1 0", bready, bvalid);
        end
        lstm_valid = 1'b1;
        @(negedge clk);
        lstm_valid = 1'b0;
        wait_mvalid(60, ok, cyc);
        n_checks++;
        if (!ok || m_y_data !== 16'h1234 || m_c_data !== 16'hFEDC || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL early_pulse_flow: ok=%b y=%h c=%h tmo=%b, required 1 1234 fedc 0",
                     ok, m_y_data, m_c_data, timeout_err);
        end
        take_output();
        b_delay = 0;
    endtask

    task automatic test_timeout();
        int ar0, mv0, b0, cyc;
        bit ok;
        ar0 = ar_hs; mv0 = mv_beats;
        send_x(16'h0055, ok);
        repeat (17) @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: tmo=%b busy=%b, required 0 1", timeout_err, busy);
        end
        @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_set: tmo=%b busy=%b, required 1 0", timeout_err, busy);
        end
        n_checks++;
        if (ar_hs != ar0 || mv_beats != mv0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_no_read: ar=%0d beats=%0d m_valid=%b, required 0 0 0",
                     ar_hs - ar0, mv_beats - mv0, m_valid);
        end
        y_val = 16'h0001; c_val = 16'h0002;
        b0 = b_hs;
        send_x(16'h0066, ok);
        pulse_lstm_after_b(3, b0);
        wait_mvalid(60, ok, cyc);
        n_checks++;
        if (!ok || m_y_data !== 16'h0001 || m_c_data !== 16'h0002) begin
            n_fail++;
            $display("FAIL timeout_next_sample: ok=%b y=%h c=%h, required 1 0001 0002",
                     ok, m_y_data, m_c_data);
        end
        take_output();
    endtask

    task automatic test_bresp_and_hold();
        int b0, mv0, bad, cyc;
        bit ok;
        cfg_bresp = 2'b10;
        y_val = 16'hAAAA; c_val = 16'h5555;
        b0 = b_hs; mv0 = mv_beats;
        send_x(16'h0777, ok);
        pulse_lstm_after_b(1, b0);
        wait_mvalid(60, ok, cyc);
        n_checks++;
        if (!ok || resp_err !== 1'b1) begin
            n_fail++;
            $display("FAIL bresp_err: ok=%b resp_err=%b, required 1 1", ok, resp_err);
        end
        bad = 0;
        s_x_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid !== 1'b1 || s_x_ready !== 1'b0 || awvalid !== 1'b0 ||
                m_y_data !== 16'hAAAA || m_c_data !== 16'h5555) bad++;
        end
        s_x_valid = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL out_hold: bad cycles=%0d, required 0", bad);
        end
        take_output();
        n_checks++;
        if (mv_beats - mv0 != 1) begin
            n_fail++;
            $display("FAIL out_hold_beats: beats=%0d, required 1", mv_beats - mv0);
        end
        cfg_bresp = 2'b00;
    endtask

    task automatic test_no_lstm_ready();
        int bad;
        bad = 0;
        lstm_ready = 1'b0;
        s_x_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (s_x_ready !== 1'b0 || busy !== 1'b0 || awvalid !== 1'b0) bad++;
        end
        s_x_valid  = 1'b0;
        lstm_ready = 1'b1;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL no_lstm_ready: bad cycles=%0d, required 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int b0, cyc;
        bit ok, seen;
        r_delay = 8;
        b0 = b_hs;
        send_x(16'h0321, ok);
        pulse_lstm_after_b(1, b0);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (rready) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!seen || resp_err !== 1'b1 || timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: rdata_y=%b resp_err=%b tmo=%b, required 1 1 1",
                     seen, resp_err, timeout_err);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (w_outs !== '0 || s_x_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: outs=%h s_x_ready=%b, required all zero and ready=1",
                     w_outs, s_x_ready);
        end
        r_delay = 0;
        @(negedge clk);
        rst = 1'b0;
        y_val = 16'h0F0F; c_val = 16'hF0F0;
        b0 = b_hs;
        send_x(16'h0999, ok);
        pulse_lstm_after_b(0, b0);
        wait_mvalid(60, ok, cyc);
        n_checks++;
        if (!ok || m_y_data !== 16'h0F0F || m_c_data !== 16'hF0F0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_flow: ok=%b y=%h c=%h resp_err=%b, required 1 0f0f f0f0 0",
                     ok, m_y_data, m_c_data, resp_err);
        end
        take_output();
        n_checks++;
        if (prot_err != 0) begin
            n_fail++;
            $display("FAIL bus_stability: violations=%0d, required 0", prot_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_skewed_ready();
        test_lstm_in_wresp();
        test_timeout();
        test_bresp_and_hold();
        test_no_lstm_ready();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
